accum_rd_arbiter: RTL
=====================

Name: accum_rd_arbiter

Overview:
Schedules and shares the skewed accumulator read controller between NUM_REQ requesters, for example output writeback and next-layer feed. It accepts one read job at a time with a valid/ready handshake and uses round-robin arbitration. For each accepted job it drives the controller's one-cycle start pulse and row count, holds the row count stable while the controller runs, and pulses a per-requester done when the skewed read has fully drained. It sits between the requesters and the accumulator read controller; its outputs connect directly to that controller's rd_en_in and num_row inputs.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
SYS_ROW, 16, systolic array rows
SYS_COL, 16, systolic array columns
DATA_WIDTH, 16, width of num_row fields
ACCUM_SIZE, 4096, accumulator entries; ACCUM_ROW = ACCUM_SIZE/SYS_COL (localparam, 256 at defaults)
DRAIN_CYC, SYS_ROW+3, cycles after the 2*num_row read window until the last skewed row has been delivered

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester job request
req_num_row  in  NUM_REQ x DATA_WIDTH  rows requested, unpacked array [0:NUM_REQ-1]
req_ready  out  NUM_REQ  one-hot grant; a job transfers when valid&ready
done  out  NUM_REQ  one-cycle pulse to the owner when its job completes
rd_en_in  out  1  start pulse to the read controller
num_row  out  DATA_WIDTH  row count to the read controller, stable while busy
busy  out  1  a job is in flight
owner  out  $clog2(NUM_REQ) (min 1)  index of the current or last owner

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0; round-robin pointer 0; counter 0. Reset mid-job aborts the job with no done pulse. The read controller shares rstn.
- States: IDLE, ISSUE, RUN.
- IDLE:
  - req_ready is combinational: one-hot on the first valid requester at or after the round-robin pointer; 0 if none valid. req_ready is 0 in every other state.
  - On handshake: latch n = min(req_num_row[w], ACCUM_ROW); drive num_row = n from the next cycle; owner <= w; go to ISSUE.
- ISSUE, one cycle, busy=1:
  - n>0: rd_en_in=1 this cycle only; load the counter so that done fires exactly 2*n+DRAIN_CYC cycles after this cycle; go to RUN.
  - n=0: no rd_en_in; done[owner]=1 this cycle; go to IDLE.
- RUN, busy=1: decrement the counter each cycle. At terminal count, done[owner]=1 for one cycle, then go to IDLE.
- Round-robin update: the pointer becomes (owner+1) mod NUM_REQ in the cycle done fires.
- Throughput: the earliest next handshake is the cycle after done. Back-to-back jobs never overlap in the read controller.
- num_row and owner hold their last values in IDLE. busy is high from ISSUE through the done cycle inclusive.
- Input stability: requesters keep req_valid and req_num_row stable until the handshake. Dropping req_valid before the handshake is legal and simply withdraws the request.
- Counter width: CNT_W = $clog2(2*ACCUM_ROW+DRAIN_CYC)+1. Arithmetic is unsigned; clamping happens before doubling, so the counter cannot overflow.

Optional Feature:
ACCUM_RD_PERF_EN
- Defined: adds outputs perf_busy_cyc[31:0] (increments each cycle busy=1) and perf_stall_cyc[31:0] (increments each cycle any req_valid=1 while state is not IDLE). Both saturate at all-ones and reset to 0 on rstn.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package accum_pkg: ACCUM_ROW computation, the count-width function, and the state enum typedef (IDLE/ISSUE/RUN).
- One sub-module, rr_arbiter: round-robin one-hot picker parameterised by NUM_REQ, taking valid and pointer and returning grant. Shared with future requester muxes.

Test Plan:
- Reset then req_valid[0]=1, num_row=4, handshake at T -> rd_en_in=1 at T+1 only; num_row=4 from T+1; busy T+1..T+28; done[0] at T+28.
- Both requesters valid continuously with num_row=2 -> grants alternate 0,1,0,1; each next handshake lands exactly one cycle after the previous done.
- req_num_row=300 -> num_row=256; done at T+1+512+19 = T+532.
- req_num_row=0 -> no rd_en_in; done at T+1; returns to IDLE; next handshake possible at T+2.
- rstn low during RUN -> all outputs 0 immediately; no done; after release a new request is accepted normally, starting from pointer 0.
- With ACCUM_RD_PERF_EN, one num_row=4 job while requester 1 waits throughout -> perf_busy_cyc=28; perf_stall_cyc counts each cycle requester 1 is valid outside IDLE.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and sizing helpers for the accumulator read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t      - arbiter FSM states (IDLE / ISSUE / RUN)
//   accum_rows() - accumulator rows = entries / array columns
//   cnt_width()  - width of a down-counter spanning the longest read plus drain
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic int accum_rows(input int accum_size, input int sys_col);
        return accum_size / sys_col;
    endfunction

    // The extra bit keeps the worst-case load value representable even when
    // 2*accum_row + drain_cyc lands exactly on a power of two.
    function automatic int cnt_width(input int accum_row, input int drain_cyc);
        return $clog2(2 * accum_row + drain_cyc) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: first valid requester at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the grant is advisory and the caller qualifies it.
//
// Ports:
//   valid     - request vector
//   ptr       - index with highest priority this cycle (must be < NUM_REQ)
//   grant     - one-hot grant, all zero when nothing is valid
//   grant_idx - binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Walk (ptr + i) mod NUM_REQ; one extra bit absorbs the carry
            // before the single conditional subtract.
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/accum_rd_arbiter.sv
// Shares the skewed accumulator read controller between NUM_REQ requesters.
// Latency: start pulse 1 cycle after handshake; done 2*n+DRAIN_CYC cycles after the start pulse.
// Backpressure: one job in flight; req_ready is low from ISSUE through the done cycle.
//
// Optional feature macro: ACCUM_RD_PERF_EN adds perf_busy_cyc / perf_stall_cyc.
//
// Ports:
//   clk, rstn       - clock, asynchronous active-low reset
//   req_valid       - per-requester job request
//   req_num_row     - per-requester row count (clamped to ACCUM_ROW on accept)
//   req_ready       - one-hot grant, only while idle
//   done            - one-cycle completion pulse to the job owner
//   rd_en_in        - start pulse to the read controller
//   num_row         - row count to the read controller, stable while busy
//   busy            - a job is in flight
//   owner           - current or last job owner
//   perf_busy_cyc   - (ACCUM_RD_PERF_EN) saturating count of busy cycles
//   perf_stall_cyc  - (ACCUM_RD_PERF_EN) saturating count of cycles a request waits on a job
module accum_rd_arbiter
    import accum_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 4096,
    parameter int DRAIN_CYC  = SYS_ROW + 3,
    localparam int OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [DATA_WIDTH-1:0] req_num_row [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    done,
    output logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] num_row,
    output logic                  busy,
`ifdef ACCUM_RD_PERF_EN
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc,
`endif
    output logic [OWNER_W-1:0]    owner
);

    localparam int ACCUM_ROW = accum_rows(ACCUM_SIZE, SYS_COL);
    localparam int CNT_W     = cnt_width(ACCUM_ROW, DRAIN_CYC);

    localparam logic [DATA_WIDTH-1:0] ROW_MAX = DATA_WIDTH'(ACCUM_ROW);
    localparam logic [OWNER_W-1:0]    LAST_REQ = OWNER_W'(NUM_REQ - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   num_row_q;
    logic [OWNER_W-1:0]      owner_q;
    logic [OWNER_W-1:0]      ptr_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [NUM_REQ-1:0]      grant;
    logic [OWNER_W-1:0]      grant_idx;
    logic                    idle;
    logic                    hs;
    logic                    zero_job;
    logic                    done_evt;
    logic [DATA_WIDTH-1:0]   sel_row;
    logic [DATA_WIDTH-1:0]   clamped_row;
    logic [CNT_W-1:0]        cnt_load;
    logic [OWNER_W-1:0]      ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign idle = (state_q == IDLE);
    // Gated by rstn so every output reads 0 while reset is held, even with
    // requests pending.
    assign req_ready = (idle && rstn) ? grant : '0;
    assign hs        = |(req_valid & req_ready);

    // Clamp before doubling so the counter load can never overflow CNT_W.
    assign sel_row     = req_num_row[grant_idx];
    assign clamped_row = (sel_row > ROW_MAX) ? ROW_MAX : sel_row;

    assign zero_job = (num_row_q == '0);
    // ISSUE is the first cycle of the 2*n+DRAIN_CYC window, so the RUN phase
    // counts the remaining cycles down to zero inclusive.
    assign cnt_load = CNT_W'({num_row_q, 1'b0}) + CNT_W'(DRAIN_CYC - 1);
    assign ptr_next = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;

    assign num_row = num_row_q;
    assign owner   = owner_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en_in = 1'b0;
        busy     = 1'b0;
        done_evt = 1'b0;
        done     = '0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (zero_job) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end else begin
                    rd_en_in = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (done_evt) begin
            done[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_row_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (hs) begin
                num_row_q <= clamped_row;
                owner_q   <= grant_idx;
            end
            if (state_q == ISSUE && !zero_job) begin
                cnt_q <= cnt_load;
            end else if (state_q == RUN && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done_evt) begin
                ptr_q <= ptr_next;
            end
        end
    end

`ifdef ACCUM_RD_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 1'b1;
            end
            if ((|req_valid) && !idle && perf_stall_cyc != '1) begin
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
